// File: rtl/osd_pkg.sv
// Shared definitions for the OSD VRAM write scheduler: fill FSM states,
// grant-source encoding and default widths.
package osd_pkg;

  localparam int unsigned C_DAT_W_DEF   = 8;
  localparam int unsigned C_ADR_W_DEF   = 10;
  localparam int unsigned C_FIFO_AW_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_e;

  typedef enum logic {
    GNT_CPU  = 1'b0,
    GNT_FILL = 1'b1
  } gnt_e;

endpackage

// File: rtl/osd_vram_wr_arb_if.sv
// Bus bundle between the CPU/fill sources, the write scheduler and the
// character generator's VRAM write port.
interface osd_vram_wr_arb_if
  import osd_pkg::*;
#(
  parameter int unsigned C_DAT_W = C_DAT_W_DEF,
  parameter int unsigned C_ADR_W = C_ADR_W_DEF
) ();

  logic [C_DAT_W-1:0] CPU_WDs_i;
  logic [C_ADR_W-1:0] CPU_WAs_i;
  logic               CPU_WE_i;
  logic               CPU_RDY_o;
  logic               FILL_REQ_i;
  logic [C_DAT_W-1:0] FILL_CODEs_i;
  logic               FILL_BUSY_o;
  logic               FILL_DONE_o;
  logic [C_DAT_W-1:0] VRAM_WDs_o;
  logic [C_ADR_W-1:0] VRAM_WAs_o;
  logic               VRAM_WE_o;

  modport slave (
    input  CPU_WDs_i, CPU_WAs_i, CPU_WE_i, FILL_REQ_i, FILL_CODEs_i,
    output CPU_RDY_o, FILL_BUSY_o, FILL_DONE_o,
           VRAM_WDs_o, VRAM_WAs_o, VRAM_WE_o
  );

  modport master (
    output CPU_WDs_i, CPU_WAs_i, CPU_WE_i, FILL_REQ_i, FILL_CODEs_i,
    input  CPU_RDY_o, FILL_BUSY_o, FILL_DONE_o,
           VRAM_WDs_o, VRAM_WAs_o, VRAM_WE_o
  );

endinterface

// File: rtl/osd_wr_fifo.sv
// Small synchronous FIFO buffering CPU writes ({addr, data}) until a VRAM
// write slot is granted. Full/empty are derived from an occupancy counter.
module osd_wr_fifo #(
  parameter int unsigned C_FIFO_AW = 2,
  parameter int unsigned C_W       = 18
) (
  input  logic           CK_i,
  input  logic           R_i,
  input  logic           push,
  input  logic [C_W-1:0] push_data,
  input  logic           pop,
  output logic [C_W-1:0] pop_data,
  output logic           full,
  output logic           empty
);

  localparam int unsigned    DEPTH_I = 1 << C_FIFO_AW;
  localparam logic [C_FIFO_AW:0] DEPTH = (C_FIFO_AW+1)'(DEPTH_I);

  logic [C_W-1:0]       mem [DEPTH_I];
  logic [C_FIFO_AW-1:0] wr_ptr;
  logic [C_FIFO_AW-1:0] rd_ptr;
  logic [C_FIFO_AW:0]   count;
  logic                 do_push;
  logic                 do_pop;

  assign full     = (count == DEPTH);
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge CK_i) begin
    if (R_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are valid, and an unreset array maps onto plain RAM/regs.
  always_ff @(posedge CK_i) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/osd_vram_wr_arb.sv
// OSD VRAM single-write-port scheduler: CPU FIFO plus screen-fill engine
// sharing one slot per CK_EE_i. Fill is compiled in only with OSD_VRAM_FILL_EN.
module osd_vram_wr_arb
  import osd_pkg::*;
#(
  parameter int unsigned C_DAT_W   = C_DAT_W_DEF,
  parameter int unsigned C_ADR_W   = C_ADR_W_DEF,
  parameter int unsigned C_FIFO_AW = C_FIFO_AW_DEF
) (
  input  logic                CK_i,
  input  logic                R_i,
  input  logic                CK_EE_i,
  osd_vram_wr_arb_if.slave    bus
);

  localparam int unsigned C_FW = C_DAT_W + C_ADR_W;

  logic [C_FW-1:0]    fifo_din;
  logic [C_FW-1:0]    fifo_dout;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;

  logic               gnt_valid;
  gnt_e               gnt_src;
  logic [C_DAT_W-1:0] fill_wd;
  logic [C_ADR_W-1:0] fill_wa;

  logic [C_DAT_W-1:0] vram_wd_q;
  logic [C_ADR_W-1:0] vram_wa_q;
  logic               vram_we_q;

  assign fifo_din      = {bus.CPU_WAs_i, bus.CPU_WDs_i};
  assign bus.CPU_RDY_o = ~fifo_full;
  assign fifo_pop      = gnt_valid && (gnt_src == GNT_CPU);

  osd_wr_fifo #(
    .C_FIFO_AW (C_FIFO_AW),
    .C_W       (C_FW)
  ) u_fifo (
    .CK_i      (CK_i),
    .R_i       (R_i),
    .push      (bus.CPU_WE_i),
    .push_data (fifo_din),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef OSD_VRAM_FILL_EN

  fill_state_e        state_q, state_d;
  logic [C_ADR_W:0]   cnt_q, cnt_d;
  logic [C_DAT_W-1:0] code_q, code_d;
  gnt_e               last_q, last_d;

  always_ff @(posedge CK_i) begin
    if (R_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      last_q  <= GNT_FILL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      last_q  <= last_d;
    end
  end

  // NOTE: every variable gets a default first so no path through this block
  // leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    last_d    = last_q;
    gnt_valid = 1'b0;
    gnt_src   = GNT_CPU;

    if (CK_EE_i) begin
      unique case ({~fifo_empty, state_q == ST_FILL})
        2'b10: begin
          gnt_valid = 1'b1;
          gnt_src   = GNT_CPU;
        end
        2'b01: begin
          gnt_valid = 1'b1;
          gnt_src   = GNT_FILL;
        end
        2'b11: begin
          // Round-robin memory only moves on contested slots.
          gnt_valid = 1'b1;
          gnt_src   = (last_q == GNT_FILL) ? GNT_CPU : GNT_FILL;
          last_d    = gnt_src;
        end
        default: ;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.FILL_REQ_i) begin
          state_d = ST_FILL;
          code_d  = bus.FILL_CODEs_i;
          cnt_d   = '0;
        end
      end
      ST_FILL: begin
        if (gnt_valid && (gnt_src == GNT_FILL)) begin
          cnt_d = cnt_q + (C_ADR_W+1)'(1);
          // MSB set means the last cell has just been issued.
          if (cnt_d[C_ADR_W]) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign fill_wd         = code_q;
  assign fill_wa         = cnt_q[C_ADR_W-1:0];
  assign bus.FILL_BUSY_o = (state_q == ST_FILL);
  assign bus.FILL_DONE_o = (state_q == ST_DONE);

`else

  // Without the fill engine the FIFO owns every slot.
  logic unused_fill;
  assign unused_fill     = ^{bus.FILL_REQ_i, bus.FILL_CODEs_i};
  assign gnt_valid       = CK_EE_i & ~fifo_empty;
  assign gnt_src         = GNT_CPU;
  assign fill_wd         = '0;
  assign fill_wa         = '0;
  assign bus.FILL_BUSY_o = 1'b0;
  assign bus.FILL_DONE_o = 1'b0;

`endif

  // Output register holds each slot's write for the full CK_EE_i period.
  always_ff @(posedge CK_i) begin
    if (R_i) begin
      vram_wd_q <= '0;
      vram_wa_q <= '0;
      vram_we_q <= 1'b0;
    end else if (CK_EE_i) begin
      vram_we_q <= gnt_valid;
      if (gnt_valid) begin
        if (gnt_src == GNT_CPU) begin
          vram_wa_q <= fifo_dout[C_FW-1:C_DAT_W];
          vram_wd_q <= fifo_dout[C_DAT_W-1:0];
        end else begin
          vram_wa_q <= fill_wa;
          vram_wd_q <= fill_wd;
        end
      end
    end
  end

  assign bus.VRAM_WDs_o = vram_wd_q;
  assign bus.VRAM_WAs_o = vram_wa_q;
  assign bus.VRAM_WE_o  = vram_we_q;

endmodule

// File: tb/tb_osd_vram_wr_arb.sv
// Scoreboard bench for osd_vram_wr_arb; fill scenarios run when
// OSD_VRAM_FILL_EN is defined, the disabled-fill scenario otherwise.
module tb_osd_vram_wr_arb;

  typedef struct packed {
    logic [9:0] wa;
    logic [7:0] wd;
  } exp_t;

  logic       CK_i;
  logic       R_i;
  logic       CK_EE_i;
  logic       ee_en;
  logic [2:0] phase;

  exp_t exp_q[$];
  int   n_checks;
  int   n_pass;
  int   slot_cnt;
  int   last_pop_slot;
  int   wr_cnt;
  int   done_cnt;
  int   done_wa;
  int   done_we;
  int   busy_gaps;
  int   busy_seen;
  logic fill_watch;

  osd_vram_wr_arb_if #(.C_DAT_W(8), .C_ADR_W(10)) bus ();

  osd_vram_wr_arb #(.C_DAT_W(8), .C_ADR_W(10), .C_FIFO_AW(2)) dut (
    .CK_i    (CK_i),
    .R_i     (R_i),
    .CK_EE_i (CK_EE_i),
    .bus     (bus)
  );

  initial begin
    CK_i = 1'b0;
    forever #5 CK_i = ~CK_i;
  end

  initial begin
    CK_EE_i = 1'b0;
    phase   = '0;
    forever begin
      @(negedge CK_i);
      phase   = phase + 3'd1;
      CK_EE_i = ee_en && (phase == 3'd7);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
  endtask

  // Scoreboard: every write seen on a slot edge is compared against the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge CK_i);
      if (CK_EE_i && !R_i) begin
        slot_cnt++;
        #1;
        if (bus.VRAM_WE_o) begin
          wr_cnt++;
          if (exp_q.size() == 0) begin
            check("spurious_we", 32'(bus.VRAM_WE_o), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("vram_wa", 32'(bus.VRAM_WAs_o), 32'(e.wa));
            check("vram_wd", 32'(bus.VRAM_WDs_o), 32'(e.wd));
            last_pop_slot = slot_cnt;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge CK_i);
      if (bus.FILL_BUSY_o) busy_seen++;
      if (bus.FILL_DONE_o) begin
        done_cnt++;
        done_wa = 32'(bus.VRAM_WAs_o);
        done_we = 32'(bus.VRAM_WE_o);
      end
      if (fill_watch) begin
        if (bus.FILL_DONE_o) fill_watch = 1'b0;
        else if (!bus.FILL_BUSY_o) busy_gaps++;
      end
    end
  end

  // Called at a negedge; returns at a negedge with the write accepted.
  task automatic cpu_write(input logic [9:0] wa, input logic [7:0] wd, output int acc_slot);
    int   n;
    exp_t e;
    bus.CPU_WAs_i = wa;
    bus.CPU_WDs_i = wd;
    bus.CPU_WE_i  = 1'b1;
    n = 0;
    while (!bus.CPU_RDY_o && n < 200) begin
      @(negedge CK_i);
      n++;
    end
    check("wr_accept", 32'(bus.CPU_RDY_o), 32'd1);
    e.wa = wa;
    e.wd = wd;
    exp_q.push_back(e);
    @(negedge CK_i);
    bus.CPU_WE_i = 1'b0;
    acc_slot = slot_cnt + 1;
  endtask

  task automatic wait_ee();
    int n;
    n = 0;
    do begin
      @(posedge CK_i);
      n++;
    end while (!CK_EE_i && n < 64);
    if (!CK_EE_i) check("ee_timeout", 32'(CK_EE_i), 32'd1);
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge CK_i);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_we"},   32'(bus.VRAM_WE_o),   32'd0);
    check({pfx, "_wa"},   32'(bus.VRAM_WAs_o),  32'd0);
    check({pfx, "_wd"},   32'(bus.VRAM_WDs_o),  32'd0);
    check({pfx, "_rdy"},  32'(bus.CPU_RDY_o),   32'd1);
    check({pfx, "_busy"}, 32'(bus.FILL_BUSY_o), 32'd0);
    check({pfx, "_done"}, 32'(bus.FILL_DONE_o), 32'd0);
  endtask

  task automatic push_fill(input int first, input int last, input logic [7:0] code);
    exp_t e;
    for (int a = first; a <= last; a++) begin
      e.wa = 10'(a);
      e.wd = code;
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_fill(input logic [7:0] code);
    @(negedge CK_i);
    bus.FILL_REQ_i   = 1'b1;
    bus.FILL_CODEs_i = code;
    @(negedge CK_i);
    bus.FILL_REQ_i   = 1'b0;
  endtask

  initial begin
    int   acc;
    int   d0;
    int   w0;
    exp_t e;

    n_checks = 0; n_pass = 0; slot_cnt = 0; last_pop_slot = 0; wr_cnt = 0;
    done_cnt = 0; done_wa = 0; done_we = 0; busy_gaps = 0; busy_seen = 0;
    fill_watch = 1'b0;
    ee_en = 1'b0;
    R_i   = 1'b1;
    bus.CPU_WDs_i = '0; bus.CPU_WAs_i = '0; bus.CPU_WE_i = 1'b0;
    bus.FILL_REQ_i = 1'b0; bus.FILL_CODEs_i = '0;

    repeat (4) @(negedge CK_i);
    check_reset_vals("rst_hold");
    R_i = 1'b0;
    @(negedge CK_i);
    check_reset_vals("rst");

    // Single uncontested CPU write and its one-slot latency.
    ee_en = 1'b1;
    wait_ee();
    @(negedge CK_i);
    cpu_write(10'h005, 8'h41, acc);
    drain(64);
    check("cpu_latency_slot", 32'(last_pop_slot), 32'(acc));
    wait_ee();
    #1;
    check("we_idle_slot", 32'(bus.VRAM_WE_o), 32'd0);

    // FIFO full: four back-to-back writes with no slots, fifth held.
    @(negedge CK_i);
    ee_en = 1'b0;
    repeat (2) @(negedge CK_i);
    for (int i = 0; i < 4; i++) cpu_write(10'(10'h010 + i), 8'(8'h60 + i), acc);
    check("fifo_full_rdy", 32'(bus.CPU_RDY_o), 32'd0);
    check("fifo_full_nowr", 32'(wr_cnt), 32'd1);
    ee_en = 1'b1;
    cpu_write(10'h014, 8'h64, acc);
    drain(5 * 8 + 64);

`ifdef OSD_VRAM_FILL_EN
    // Fill only.
    d0 = done_cnt;
    busy_gaps = 0;
    push_fill(0, 1023, 8'h20);
    pulse_fill(8'h20);
    fill_watch = 1'b1;
    drain(1024 * 8 + 64);
    repeat (3) @(negedge CK_i);
    check("fill_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("fill_busy_gaps", 32'(busy_gaps), 32'd0);
    check("fill_done_wa", 32'(done_wa), 32'd1023);
    check("fill_done_we", 32'(done_we), 32'd1);
    check("fill_idle_busy", 32'(bus.FILL_BUSY_o), 32'd0);
    fill_watch = 1'b0;

    // Contention: CPU wins first contested slot, then alternation.
    e.wa = 10'h100; e.wd = 8'hA1; exp_q.push_back(e);
    e.wa = 10'h000; e.wd = 8'h33; exp_q.push_back(e);
    e.wa = 10'h101; e.wd = 8'hA2; exp_q.push_back(e);
    e.wa = 10'h001; e.wd = 8'h33; exp_q.push_back(e);
    e.wa = 10'h102; e.wd = 8'hA3; exp_q.push_back(e);
    push_fill(2, 1023, 8'h33);
    wait_ee();
    @(negedge CK_i);
    check("cont_rdy0", 32'(bus.CPU_RDY_o), 32'd1);
    bus.FILL_REQ_i = 1'b1; bus.FILL_CODEs_i = 8'h33;
    bus.CPU_WE_i = 1'b1; bus.CPU_WAs_i = 10'h100; bus.CPU_WDs_i = 8'hA1;
    @(negedge CK_i);
    bus.FILL_REQ_i = 1'b0;
    check("cont_rdy1", 32'(bus.CPU_RDY_o), 32'd1);
    bus.CPU_WAs_i = 10'h101; bus.CPU_WDs_i = 8'hA2;
    @(negedge CK_i);
    check("cont_rdy2", 32'(bus.CPU_RDY_o), 32'd1);
    bus.CPU_WAs_i = 10'h102; bus.CPU_WDs_i = 8'hA3;
    @(negedge CK_i);
    bus.CPU_WE_i = 1'b0;
    drain(1027 * 8 + 64);
    repeat (3) @(negedge CK_i);

    // Reset mid-fill at address 300, then restart from 0.
    push_fill(0, 300, 8'h55);
    pulse_fill(8'h55);
    drain(301 * 8 + 64);
    d0 = done_cnt;
    R_i = 1'b1;
    exp_q.delete();
    @(negedge CK_i);
    check_reset_vals("abort");
    @(negedge CK_i);
    R_i = 1'b0;
    w0 = wr_cnt;
    repeat (48) @(negedge CK_i);
    check("abort_no_done", 32'(done_cnt), 32'(d0));
    check("abort_no_wr", 32'(wr_cnt), 32'(w0));
    check("abort_busy", 32'(bus.FILL_BUSY_o), 32'd0);
    push_fill(0, 15, 8'h66);
    pulse_fill(8'h66);
    drain(16 * 8 + 64);
    R_i = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge CK_i);
    R_i = 1'b0;
    @(negedge CK_i);
`else
    // Fill disabled: requests ignored, CPU path unaffected.
    d0 = done_cnt;
    w0 = wr_cnt;
    busy_seen = 0;
    pulse_fill(8'h77);
    repeat (48) @(negedge CK_i);
    check("off_busy", 32'(busy_seen), 32'd0);
    check("off_done", 32'(done_cnt), 32'(d0));
    check("off_no_wr", 32'(wr_cnt), 32'(w0));
    cpu_write(10'h3FF, 8'h99, acc);
    drain(64);
    check("off_cpu_latency", 32'(last_pop_slot), 32'(acc));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/osd_vram_wr_arb.md
# osd_vram_wr_arb

Single-write-port scheduler for the OSD character VRAM. It sits between the CPU register bus and the character generator's VRAM write port. CPU writes pass through a small FIFO, and a built-in screen-fill engine clears or fills all 1024 character cells. Both sources share one write slot per CK_EE_i strobe (FSC4 rate), under round-robin arbitration.

## Interface
- C_DAT_W, 8, character code width
- C_ADR_W, 10, VRAM address width; fill covers 0 .. 2^C_ADR_W-1
- C_FIFO_AW, 2, log2 of CPU FIFO depth (default 4 entries)

Ports:
- CK_i  in  1  system clock (FSC32)
- R_i  in  1  reset, synchronous, active-high
- CK_EE_i  in  1  write-slot strobe, one CK_i cycle wide, every 8 CK_i
- CPU_WDs_i  in  C_DAT_W  CPU write data
- CPU_WAs_i  in  C_ADR_W  CPU write address
- CPU_WE_i  in  1  CPU write valid
- CPU_RDY_o  out  1  FIFO can accept; a write is taken when CPU_WE_i & CPU_RDY_o
- FILL_REQ_i  in  1  start fill (level sampled, edge not required)
- FILL_CODEs_i  in  C_DAT_W  fill code, latched at fill start
- FILL_BUSY_o  out  1  fill in progress
- FILL_DONE_o  out  1  one CK_i pulse after the last fill write is issued
- VRAM_WDs_o  out  C_DAT_W  to character generator write data
- VRAM_WAs_o  out  C_ADR_W  to character generator write address
- VRAM_WE_o  out  1  to character generator write enable

## Operation
- CPU FIFO:
  - CPU_RDY_o = ~full.
  - A push in the same cycle as a pop is allowed when not full.
  - An entry pushed in cycle t is not eligible for a slot in cycle t.
- Fill FSM, states IDLE, FILL, DONE:
  - IDLE: FILL_REQ_i=1 → FILL. Latch FILL_CODEs_i; fill address counter = 0.
  - FILL: each granted fill slot writes the counter value, then increments it.
  - After the slot at address 2^C_ADR_W-1 is granted → DONE.
  - DONE: lasts one CK_i cycle with FILL_DONE_o=1 → IDLE.
  - FILL_REQ_i is ignored in FILL and DONE.
  - FILL_BUSY_o = (state==FILL).
- Arbitration, evaluated only in cycles with CK_EE_i=1:
  - Requesters are FIFO non-empty and state==FILL.
  - With one requester, it wins.
  - With both, the source not granted last time wins; the last-grant flag updates only on contested slots.
  - With none, the result is an idle slot.
- Output register, loaded only when CK_EE_i=1:
  - Granted slot: VRAM_WDs_o/VRAM_WAs_o take the winner's data/address and VRAM_WE_o=1.
  - Idle slot: VRAM_WE_o=0; data/address hold their previous values.
  - Outputs hold for the full 8-cycle slot, so downstream logic sampling on CK_EE sees each write exactly once.

## Timing
- Reset values:
  - VRAM_WDs_o=0, VRAM_WAs_o=0, VRAM_WE_o=0.
  - CPU_RDY_o=1 (FIFO empty), FILL_BUSY_o=0, FILL_DONE_o=0.
  - FSM=IDLE, last-grant=fill (CPU wins the first contested slot).
- Latency: a CPU write accepted at cycle t, uncontested, appears on the outputs on the first CK_EE_i edge strictly after t.
- A fill of 1024 cells takes 1024 slots uncontested, and up to 2048 slots with continuous CPU traffic.
- FILL_DONE_o rises in the CK_i cycle after the CK_EE_i edge that issued address 1023.
- Address counter width: C_ADR_W+1 bits; the MSB marks wrap and ends the fill.
- R_i mid-fill aborts the fill: FSM→IDLE, FIFO flushed, no FILL_DONE_o. R_i has priority over CK_EE_i.
- FILL_REQ_i and CPU_WE_i in the same cycle are both taken.

## Configuration
- OSD_VRAM_FILL_EN defined: fill FSM and round-robin arbitration are compiled in.
- OSD_VRAM_FILL_EN undefined:
  - Fill ports remain but FILL_REQ_i and FILL_CODEs_i are ignored.
  - FILL_BUSY_o=0 and FILL_DONE_o=0 constantly.
  - The CPU FIFO owns every slot.

## Structure
- Shared package osd_pkg holds:
  - fill FSM state encoding (IDLE=0, FILL=1, DONE=2);
  - grant-source encoding (GNT_CPU, GNT_FILL);
  - default widths.
- Sub-module osd_wr_fifo: synchronous FIFO with full/empty flags, parameterised by C_FIFO_AW and data width C_DAT_W+C_ADR_W.
- Arbiter and fill FSM stay in the top module.

## Test plan
- CPU write: push WD=0x41, WA=0x005 at cycle 3, CK_EE_i at cycle 7 → VRAM_WE_o=1, WAs=0x005, WDs=0x41 during cycles 8–15; WE=0 after the next idle slot.
- FIFO full: push 5 writes back-to-back with no CK_EE_i → CPU_RDY_o=0 after the 4th; the 5th is held until a slot pops an entry; all 5 are written in order.
- Fill only: FILL_REQ_i=1 with code 0x20 → 1024 writes, addresses 0..1023 ascending, data 0x20; FILL_BUSY_o=1 throughout; single FILL_DONE_o pulse.
- Contention: fill active and CPU pushes 3 writes → slot order CPU, fill, CPU, fill, CPU, fill.
- Reset mid-fill: assert R_i at address 300 → all outputs return to reset values, no FILL_DONE_o; a new FILL_REQ_i restarts from address 0.
- Macro off: build without OSD_VRAM_FILL_EN and pulse FILL_REQ_i → no VRAM writes, FILL_BUSY_o stays 0; CPU writes are unaffected.
